// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave): one outstanding word access at a time.
interface data_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory slave for the pipeline's LW/SW port: accepts one access, waits
// WAIT_CYCLES, commits/reads on the edge entering ACK and pulses ack once.
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int              IDX_W   = $clog2(DEPTH_WORDS);
    localparam int              WA_W    = ADDR_W - 2;
    localparam logic [WA_W-1:0] DEPTH_L = WA_W'(DEPTH_WORDS);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
    localparam logic            NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        be_r;
    logic [DATA_W-1:0] rdata_r;
    logic              ack_r;
    logic              err_r;
    logic              busy_r;

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

    logic              cur_we_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [DATA_W-1:0] cur_wdata_s;
    logic [3:0]        cur_be_s;
    logic [WA_W-1:0]   word_addr_s;
    logic [IDX_W-1:0]  idx_s;
    logic              cur_err_s;
    logic              enter_ack_s;
    logic              commit_s;
    logic [DATA_W-1:0] rd_next_s;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Select the access being served: live inputs in IDLE (zero-wait path), latched fields otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = bus.we;
            cur_addr_s  = bus.addr;
            cur_wdata_s = bus.wdata;
            cur_be_s    = bus.be;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
            cur_be_s    = be_r;
        end
        word_addr_s = cur_addr_s[ADDR_W-1:2];
        idx_s       = word_addr_s[IDX_W-1:0];
        cur_err_s   = (cur_addr_s[1:0] != 2'b00) || (word_addr_s >= DEPTH_L);
    end

    // Decide whether this edge enters ACK, and what that edge commits/returns.
    always_comb begin
        case (state_r)
            ST_IDLE: enter_ack_s = bus.req && NO_WAIT;
            // <= 1 rather than == 1 so a corrupted zero count cannot hang the port
            ST_WAIT: enter_ack_s = (cnt_r <= 4'd1);
            default: enter_ack_s = 1'b0;
        endcase
        commit_s = enter_ack_s && cur_we_s && !cur_err_s && !rst;
        if (!cur_we_s && !cur_err_s) begin
            rd_next_s = mem_r[idx_s];
        end else begin
            rd_next_s = {DATA_W{1'b0}};
        end
    end

    // Byte-masked store into the array; reset never clears contents.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], cur_wdata_s, cur_be_s);
        end
    end

    // Request sequencing FSM with registered ack/err/rdata/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= 4'b0000;
            rdata_r <= {DATA_W{1'b0}};
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_r    <= bus.we;
                        addr_r  <= bus.addr;
                        wdata_r <= bus.wdata;
                        be_r    <= bus.be;
                        busy_r  <= 1'b1;
                        if (enter_ack_s) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                            err_r   <= cur_err_s;
                            rdata_r <= rd_next_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_L;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        ack_r  <= 1'b0;
                        err_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (enter_ack_s) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        err_r   <= cur_err_s;
                        rdata_r <= rd_next_s;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= {DATA_W{1'b0}};
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= {DATA_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized LW/SW
// traffic checked against an array reference model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    data_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int          nchecks = 0;
    int          nerrors = 0;
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=2 instance; checks handshake timing.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input string tag,
                          output logic [31:0] rd, output logic e);
        int lat;
        @(negedge clk);
        bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
        @(posedge clk); #1;
        bus2.req = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(bus2.busy), 32'd1);
        lat = 0;
        while (bus2.ack !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd2);
        rd = bus2.rdata;
        e  = bus2.err;
        @(posedge clk); #1;
        chk({tag, " ack_single"}, 32'(bus2.ack), 32'd0);
        chk({tag, " busy_idle"}, 32'(bus2.busy), 32'd0);
    endtask

    // Access plus reference-model prediction of err/rdata and memory update.
    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input string tag, output logic [31:0] rd);
        logic        e;
        logic        err_exp;
        logic [31:0] mask;
        err_exp = (a % 4 != 0) || (a / 4 >= 256);
        access(w, a, d, b, tag, rd, e);
        chk({tag, " err"}, 32'(e), 32'(err_exp));
        if (w) begin
            if (!err_exp) begin
                mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | (d & mask);
            end
        end else begin
            chk({tag, " rdata"}, rd, err_exp ? 32'h0000_0000 : ref_mem[a / 4]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;

        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 32'd0; bus2.wdata = 32'd0; bus2.be = 4'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0; bus0.be = 4'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack", 32'(bus2.ack), 32'd0);
        chk("reset err", 32'(bus2.err), 32'd0);
        chk("reset busy", 32'(bus2.busy), 32'd0);
        chk("reset rdata", bus2.rdata, 32'd0);
        chk("reset0 busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            op(1'b1, 32'(i * 4), $urandom, 4'hF, "init", rd);
        end

        // Full store then load
        op(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "t1 sw", rd);
        op(1'b0, 32'h10, 32'h0, 4'h0, "t1 lw", rd);
        chk("t1 const", rd, 32'hDEAD_BEEF);

        // Single-lane store merges into existing word
        op(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, "t2 sw", rd);
        op(1'b0, 32'h10, 32'h0, 4'hF, "t2 lw", rd);
        chk("t2 const", rd, 32'hDEAD_BEAA);

        // Misaligned and out-of-range accesses, plus an empty-mask store
        op(1'b0, 32'h12, 32'h0, 4'hF, "t3 misaligned", rd);
        op(1'b0, 32'h400, 32'h0, 4'hF, "t3 range", rd);
        op(1'b1, 32'h12, 32'h1234_5678, 4'hF, "t3 sw_misaligned", rd);
        op(1'b1, 32'h10, 32'h1234_5678, 4'b0000, "t3 sw_nolanes", rd);
        op(1'b0, 32'h10, 32'h0, 4'hF, "t3 lw", rd);
        chk("t3 const", rd, 32'hDEAD_BEAA);

        // Reset in the WAIT cycle (k=1) and on the commit edge (k=2)
        for (int k = 1; k <= 2; k++) begin
            op(1'b1, 32'h20, 32'h1111_1111, 4'hF, "t4 sw_old", rd);
            @(negedge clk);
            bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h20;
            bus2.wdata = 32'hBAD0_0000 + 32'(k); bus2.be = 4'hF;
            @(posedge clk); #1;
            bus2.req = 1'b0;
            repeat (k - 1) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("t4 ack_in_reset", 32'(bus2.ack), 32'd0);
            chk("t4 busy_in_reset", 32'(bus2.busy), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                chk("t4 no_ack", 32'(bus2.ack), 32'd0);
            end
            op(1'b0, 32'h20, 32'h0, 4'hF, "t4 lw", rd);
            chk("t4 const", rd, 32'h1111_1111);
        end

        // Zero-wait instance with req held high: ack/busy alternate
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h8; bus0.wdata = 32'hCAFE_F00D; bus0.be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t5 ack_pattern", 32'(bus0.ack), 32'((i % 2) == 0));
            chk("t5 busy_pattern", 32'(bus0.busy), 32'((i % 2) == 0));
        end
        bus0.req = 1'b0;
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h8;
        @(posedge clk); #1;
        bus0.req = 1'b0;
        chk("t5 lw_ack", 32'(bus0.ack), 32'd1);
        chk("t5 lw_rdata", bus0.rdata, 32'hCAFE_F00D);
        chk("t5 lw_err", 32'(bus0.err), 32'd0);
        @(posedge clk); #1;
        chk("t5 ack_drop", 32'(bus0.ack), 32'd0);
        chk("t5 rdata_drop", bus0.rdata, 32'd0);

        // Randomized traffic against the reference array
        for (int n = 0; n < 1000; n++) begin
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                a = 32'($urandom_range(0, 2047));
            end else begin
                a = 32'($urandom_range(0, 255)) * 32'd4;
            end
            op(w, a, $urandom, b, "rnd", rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
